// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared encodings and constants for the fetch-side PC controller.
// Fetch state encodings, the NOP word and the default reset PC live here.
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_hold_reg.sv
// One-entry valid/pc/inst register used both as the IF output slot and as
// the overflow hold register. Load beats move, move beats clear.
module fetch_hold_reg
    import pc_fetch_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    input  logic        move,
    input  logic [31:0] move_pc,
    input  logic [31:0] move_inst,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= 32'h0000_0000;
            inst  <= INST_NOP;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end else if (move) begin
            valid <= 1'b1;
            pc    <= move_pc;
            inst  <= move_inst;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC controller: one outstanding imem request, one-entry IF output slot
// plus a hold register, EX redirects with stale-response discard.
//
// Handshakes: a request is accepted on a cycle where imem_req && imem_gnt;
// exactly one response (imem_rvalid) follows at least one cycle later. The IF
// entry is consumed on any edge where if_valid && !stall.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_pc_src,
    input  logic [31:0] ex_new_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        flush,
    output logic        misalign,
    output logic [1:0]  state
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;

    logic         slot_load, slot_move, slot_clear, slot_free;
    logic         hold_load, hold_clear;
    logic         hold_valid;
    logic [31:0]  hold_pc, hold_inst;

    assign slot_free = !if_valid || !stall;
    assign imem_addr = pc_q;
    assign flush     = ex_pc_src;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FS_FETCH;
            pc_q     <= RESET_PC;
            pend_q   <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            misalign <= ex_pc_src && (ex_new_pc[1:0] != 2'b00);
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        slot_load  = 1'b0;
        slot_move  = 1'b0;
        slot_clear = if_valid && !stall;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        imem_req   = (state_q == FS_FETCH) && !ex_pc_src;

        if (ex_pc_src) begin
            // Redirect wins over stall and over any response arriving now.
            pc_d       = align_pc(ex_new_pc);
            slot_clear = 1'b1;
            hold_clear = 1'b1;
            unique case (state_q)
                FS_WAIT: state_d = imem_rvalid ? FS_FETCH : FS_DROP;
                FS_DROP: state_d = imem_rvalid ? FS_FETCH : FS_DROP;
                default: state_d = FS_FETCH;
            endcase
        end else begin
            unique case (state_q)
                FS_FETCH: begin
                    if (imem_gnt) begin
                        pend_d  = pc_q;
                        pc_d    = pc_q + PC_STEP;
                        state_d = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        if (slot_free) begin
                            slot_load = 1'b1;
                            state_d   = FS_FETCH;
                        end else begin
                            hold_load = 1'b1;
                            state_d   = FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (!stall) begin
                        slot_move  = hold_valid;
                        hold_clear = 1'b1;
                        state_d    = FS_FETCH;
                    end
                end
                FS_DROP: begin
                    if (imem_rvalid) begin
                        state_d = FS_FETCH;
                    end
                end
                default: state_d = FS_FETCH;
            endcase
        end
    end

    fetch_hold_reg u_slot (
        .clk       (clk),
        .rst       (rst),
        .clear     (slot_clear),
        .load      (slot_load),
        .load_pc   (pend_q),
        .load_inst (imem_rdata),
        .move      (slot_move),
        .move_pc   (hold_pc),
        .move_inst (hold_inst),
        .valid     (if_valid),
        .pc        (if_pc),
        .inst      (if_inst)
    );

    fetch_hold_reg u_hold (
        .clk       (clk),
        .rst       (rst),
        .clear     (hold_clear),
        .load      (hold_load),
        .load_pc   (pend_q),
        .load_inst (imem_rdata),
        .move      (1'b0),
        .move_pc   (32'h0000_0000),
        .move_inst (32'h0000_0000),
        .valid     (hold_valid),
        .pc        (hold_pc),
        .inst      (hold_inst)
    );

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: random imem responder, reference model of
// expected IF entries kept as a queue, and a monitor popping on consumption.
module tb_pc_fetch_sequencer;
    import pc_fetch_sequencer_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_pc_src = 1'b0;
    logic [31:0] ex_new_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        flush;
    logic        misalign;
    logic [1:0]  state;

    pc_fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_pc_src   (ex_pc_src),
        .ex_new_pc   (ex_new_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .flush       (flush),
        .misalign    (misalign),
        .state       (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int unsigned gnt_pct = 100;
    int unsigned lat_min = 0;
    int unsigned lat_max = 0;
    logic        data_force = 1'b0;
    logic [31:0] data_val = '0;
    logic        mem_busy = 1'b0;
    logic        accepted = 1'b0;
    int unsigned mem_wait = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (accepted) begin
                mem_busy = 1'b1;
                mem_wait = $urandom_range(lat_max, lat_min);
            end
            imem_rvalid = 1'b0;
            if (mem_busy) begin
                if (mem_wait == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = data_force ? data_val : $urandom;
                    mem_busy    = 1'b0;
                end else begin
                    mem_wait--;
                end
            end
            imem_gnt = ($urandom_range(99, 0) < gnt_pct);
            #3;
            accepted = imem_req && imem_gnt && !rst;
            if (rst) mem_busy = 1'b0;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_pend = '0;
    logic        m_out = 1'b0;
    logic        m_stale = 1'b0;
    logic        exp_mis = 1'b0;

    initial begin
        logic [63:0] head;
        logic        exp_req;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_pc    = RST_PC;
                m_out   = 1'b0;
                m_stale = 1'b0;
                exp_mis = 1'b0;
            end else begin
                exp_req = !m_out && (exp_q.size() < 2) && !ex_pc_src;
                chk("flush", 32'(flush), 32'(ex_pc_src));
                chk("imem_addr", imem_addr, m_pc);
                chk("imem_req", 32'(imem_req), 32'(exp_req));
                chk("misalign", 32'(misalign), 32'(exp_mis));
                chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    head = exp_q[0];
                    chk("if_pc", if_pc, head[63:32]);
                    chk("if_inst", if_inst, head[31:0]);
                end
                exp_mis = ex_pc_src && (ex_new_pc[1:0] != 2'b00);
                if (ex_pc_src) begin
                    exp_q.delete();
                    m_pc = {ex_new_pc[31:2], 2'b00};
                    if (m_out) begin
                        if (imem_rvalid) begin
                            m_out   = 1'b0;
                            m_stale = 1'b0;
                        end else begin
                            m_stale = 1'b1;
                        end
                    end
                end else begin
                    if (imem_rvalid && m_out) begin
                        if (!m_stale) exp_q.push_back({m_pend, imem_rdata});
                        m_out   = 1'b0;
                        m_stale = 1'b0;
                    end
                    if (imem_req && imem_gnt) begin
                        m_out   = 1'b1;
                        m_stale = 1'b0;
                        m_pend  = m_pc;
                        m_pc    = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && if_valid && !stall && !ex_pc_src) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry actual pc=%h inst=%h required none", if_pc, if_inst);
                end else begin
                    e = exp_q.pop_front();
                    chk("consumed_pc", if_pc, e[63:32]);
                    chk("consumed_inst", if_inst, e[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic go();
        @(posedge clk);
        #2;
        rst       = 1'b0;
        stall     = 1'b0;
        ex_pc_src = 1'b0;
        ex_new_pc = '0;
    endtask

    task automatic wait_state(input logic [1:0] s, input logic need_rv, input logic rv, input string name);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 60; n++) begin
            go();
            if (state == s && (!need_rv || imem_rvalid == rv)) begin
                found = 1'b1;
                break;
            end
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic hold_scenario(input logic do_redirect);
        logic found;
        logic reached;
        found = 1'b0;
        reached = 1'b0;
        lat_min = 0; lat_max = 0; gnt_pct = 100;
        for (int n = 0; n < 60; n++) begin
            go();
            if (if_valid && state == FS_FETCH) begin
                found = 1'b1;
                break;
            end
        end
        chk("hold_slot_full", 32'(found), 32'd1);
        stall = 1'b1;
        for (int n = 0; n < 20; n++) begin
            go();
            stall = 1'b1;
            if (state == FS_HOLD) begin
                reached = 1'b1;
                break;
            end
        end
        chk("hold_reached", 32'(reached), 32'd1);
        #3;
        chk("hold_no_req", 32'(imem_req), 32'd0);
        if (do_redirect) begin
            go();
            stall = 1'b1;
            ex_pc_src = 1'b1;
            ex_new_pc = 32'h0000_0300;
            go();
            chk("redir_hold_if_valid", 32'(if_valid), 32'd0);
            chk("redir_hold_state", 32'(state), 32'(FS_FETCH));
        end else begin
            repeat (3) begin
                go();
                stall = 1'b1;
            end
            chk("hold_kept", 32'(state), 32'(FS_HOLD));
        end
        repeat (8) go();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        go();
        #3;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_inst", if_inst, INST_NOP);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_state", 32'(state), 32'(FS_FETCH));
        chk("rst_addr", imem_addr, RST_PC);

        // Back-to-back fetches with a 1-cycle memory.
        repeat (10) go();

        // Redirect while waiting, response still in flight.
        lat_min = 2; lat_max = 2;
        wait_state(FS_WAIT, 1'b1, 1'b0, "find_wait_no_rvalid");
        ex_pc_src = 1'b1;
        ex_new_pc = 32'h0000_0100;
        data_force = 1'b1;
        data_val = 32'hDEAD_BEEF;
        #3;
        chk("flush_on_redirect", 32'(flush), 32'd1);
        go();
        chk("drop_state", 32'(state), 32'(FS_DROP));
        for (int n = 0; n < 10; n++) begin
            if (imem_rvalid) break;
            go();
        end
        data_force = 1'b0;
        lat_min = 0; lat_max = 0;
        repeat (8) go();

        // Redirect coincident with the response.
        wait_state(FS_WAIT, 1'b1, 1'b1, "find_wait_rvalid");
        ex_pc_src = 1'b1;
        ex_new_pc = 32'h0000_0200;
        go();
        chk("coinc_state", 32'(state), 32'(FS_FETCH));
        #3;
        chk("coinc_req", 32'(imem_req), 32'd1);
        chk("coinc_addr", imem_addr, 32'h0000_0200);
        repeat (6) go();

        hold_scenario(1'b0);
        hold_scenario(1'b1);

        // Misaligned redirect target.
        wait_state(FS_FETCH, 1'b0, 1'b0, "find_fetch_mis");
        ex_pc_src = 1'b1;
        ex_new_pc = 32'h0000_0102;
        go();
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_addr", imem_addr, 32'h0000_0100);
        go();
        chk("mis_clear", 32'(misalign), 32'd0);
        repeat (6) go();

        // PC wrap at the top of the address space.
        wait_state(FS_FETCH, 1'b0, 1'b0, "find_fetch_wrap");
        ex_pc_src = 1'b1;
        ex_new_pc = 32'hFFFF_FFFC;
        wait_state(FS_WAIT, 1'b0, 1'b0, "find_wait_wrap");
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        repeat (6) go();

        // Reset while a fetch is outstanding.
        lat_min = 2; lat_max = 2;
        wait_state(FS_WAIT, 1'b0, 1'b0, "find_wait_rst");
        rst = 1'b1;
        go();
        chk("midrst_state", 32'(state), 32'(FS_FETCH));
        chk("midrst_addr", imem_addr, RST_PC);
        chk("midrst_if_valid", 32'(if_valid), 32'd0);
        repeat (6) go();

        // Randomized traffic.
        gnt_pct = 70; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            go();
            stall = ($urandom_range(99, 0) < 30);
            if ($urandom_range(99, 0) < 6) begin
                ex_pc_src = 1'b1;
                ex_new_pc = $urandom;
            end
            if ($urandom_range(999, 0) < 3) rst = 1'b1;
        end
        repeat (10) go();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
